// File: rtl/access_port_responder.sv
// access_port_responder: responder end of one agent's access port.
// Buffers agent requests in a small FIFO, issues them one at a time to the
// cache controller core, and returns one completion pulse per request
// carrying the hit flag and the issue-to-done latency.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid/opcode/addr   agent request (opcode 0 = access, 1 = flush)
//   full                FIFO full, agent must hold off valid
//   overflow            sticky, set when valid arrives while full
//   retval/ret_hit/ret_lat  one-cycle completion pulse and its payload
//   core_req/core_opcode/core_addr  request presented to the core
//   core_stall          core cannot accept this cycle
//   core_done/core_hit  core completion and hit result
module access_port_responder #(
  parameter int unsigned ADDR_LEN = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LAT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic                opcode,
  input  logic [ADDR_LEN-1:0] addr,
  output logic                full,
  output logic                retval,
  output logic                ret_hit,
  output logic [LAT_W-1:0]    ret_lat,
  output logic                overflow,
  output logic                core_req,
  output logic                core_opcode,
  output logic [ADDR_LEN-1:0] core_addr,
  input  logic                core_stall,
  input  logic                core_done,
  input  logic                core_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_LEN + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_MAX  = {LAT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              retval_q, retval_d;
  logic              ret_hit_q, ret_hit_d;
  logic [LAT_W-1:0]  ret_lat_q, ret_lat_d;
  logic              core_req_q, core_req_d;
  logic              core_opcode_q, core_opcode_d;
  logic [ADDR_LEN-1:0] core_addr_q, core_addr_d;

  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  // FIFO bookkeeping; admission uses the registered full flag (pre-edge count)
  always_comb begin
    push       = valid && !full_q;
    pop        = (state_q == S_ISSUE) && !core_stall;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d     = (count_d == CNT_FULL);
    overflow_d = overflow_q || (valid && full_q);
    head       = mem_q[rd_ptr_q];
  end

  // Storage array needs no reset: occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {opcode, addr};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    retval_d      = 1'b0;
    ret_hit_d     = 1'b0;
    ret_lat_d     = '0;
    core_req_d    = 1'b0;
    core_opcode_d = core_opcode_q;
    core_addr_d   = core_addr_q;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!core_stall) begin
          lat_d = LAT_W'(1);
          if (core_done) begin
            state_d   = S_RESP;
            retval_d  = 1'b1;
            ret_hit_d = core_hit;
            ret_lat_d = LAT_W'(1);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (core_done) begin
          state_d   = S_RESP;
          retval_d  = 1'b1;
          ret_hit_d = core_hit;
          ret_lat_d = lat_q;
        end else if (lat_q != LAT_MAX) begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_RESP: begin
        state_d = (count_q != '0) ? S_ISSUE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Head is stable whenever ISSUE is entered or held: no pop happens
    // in IDLE, RESP, or a stalled ISSUE cycle
    if (state_d == S_ISSUE) begin
      core_req_d                  = 1'b1;
      {core_opcode_d, core_addr_d} = head;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      lat_q         <= '0;
      retval_q      <= 1'b0;
      ret_hit_q     <= 1'b0;
      ret_lat_q     <= '0;
      core_req_q    <= 1'b0;
      core_opcode_q <= 1'b0;
      core_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      lat_q         <= lat_d;
      retval_q      <= retval_d;
      ret_hit_q     <= ret_hit_d;
      ret_lat_q     <= ret_lat_d;
      core_req_q    <= core_req_d;
      core_opcode_q <= core_opcode_d;
      core_addr_q   <= core_addr_d;
    end
  end

  assign full        = full_q;
  assign overflow    = overflow_q;
  assign retval      = retval_q;
  assign ret_hit     = ret_hit_q;
  assign ret_lat     = ret_lat_q;
  assign core_req    = core_req_q;
  assign core_opcode = core_opcode_q;
  assign core_addr   = core_addr_q;

endmodule

// File: tb/tb_access_port_responder.sv
// Testbench for access_port_responder: directed scenarios plus a randomized
// run checked against a queue-based model of the port.
module tb_access_port_responder;

  localparam int unsigned ADDR_LEN = 8;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned LAT_W    = 8;
  localparam int          LAT_SAT  = (1 << LAT_W) - 1;

  typedef struct packed {
    logic                op;
    logic [ADDR_LEN-1:0] a;
  } req_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                valid = 1'b0;
  logic                opcode = 1'b0;
  logic [ADDR_LEN-1:0] addr = '0;
  logic                core_stall = 1'b0;
  logic                core_done = 1'b0;
  logic                core_hit = 1'b0;
  logic                full;
  logic                retval;
  logic                ret_hit;
  logic [LAT_W-1:0]    ret_lat;
  logic                overflow;
  logic                core_req;
  logic                core_opcode;
  logic [ADDR_LEN-1:0] core_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_LEN-1:0] obs_addr[$];
  logic                obs_hit[$];
  logic [LAT_W-1:0]    obs_lat[$];

  access_port_responder #(
    .ADDR_LEN(ADDR_LEN), .DEPTH(DEPTH), .LAT_W(LAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode), .addr(addr),
    .full(full), .retval(retval), .ret_hit(ret_hit), .ret_lat(ret_lat),
    .overflow(overflow), .core_req(core_req), .core_opcode(core_opcode),
    .core_addr(core_addr), .core_stall(core_stall), .core_done(core_done),
    .core_hit(core_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; opcode = 1'b0; addr = '0;
    core_stall = 1'b0; core_done = 1'b0; core_hit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_core_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Acts as the core: accepts each issued request, completes it dly cycles
  // after acceptance with hit = addr[0], and records what it observes
  task automatic serve(input int cycles, input int dly);
    bit   busy;
    int   wait_cnt;
    logic tag;
    busy = 1'b0; wait_cnt = 0; tag = 1'b0;
    obs_addr.delete(); obs_hit.delete(); obs_lat.delete();
    core_stall = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      core_done = 1'b0; core_hit = 1'b0;
      if (retval) begin
        obs_hit.push_back(ret_hit);
        obs_lat.push_back(ret_lat);
      end
      if (busy) begin
        wait_cnt++;
        if (wait_cnt == dly) begin
          core_done = 1'b1; core_hit = tag; busy = 1'b0;
        end
      end else if (core_req) begin
        obs_addr.push_back(core_addr);
        tag = core_addr[0]; busy = 1'b1; wait_cnt = 0;
      end
      @(negedge clk);
    end
    core_done = 1'b0; core_hit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full); end
    n_vec++; if (retval !== 1'b0) begin n_err++; $display("FAIL rst_retval got %b want 0", retval); end
    n_vec++; if (ret_hit !== 1'b0) begin n_err++; $display("FAIL rst_ret_hit got %b want 0", ret_hit); end
    n_vec++; if (ret_lat !== '0) begin n_err++; $display("FAIL rst_ret_lat got %0d want 0", ret_lat); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_vec++; if (core_req !== 1'b0) begin n_err++; $display("FAIL rst_core_req got %b want 0", core_req); end
    n_vec++; if (core_opcode !== 1'b0) begin n_err++; $display("FAIL rst_core_opcode got %b want 0", core_opcode); end
    n_vec++; if (core_addr !== '0) begin n_err++; $display("FAIL rst_core_addr got %h want 0", core_addr); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); valid = 1'b1; opcode = 1'b0; addr = 8'h2A;
    @(negedge clk); valid = 1'b0;
    n_vec++; if (core_req !== 1'b0) begin n_err++; $display("FAIL single_req_early got %b want 0", core_req); end
    @(negedge clk);
    n_vec++; if (core_req !== 1'b1 || core_addr !== 8'h2A || core_opcode !== 1'b0) begin
      n_err++; $display("FAIL single_issue got req=%b addr=%h op=%b want req=1 addr=2a op=0", core_req, core_addr, core_opcode);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++; if (full !== 1'b0 || retval !== 1'b0) begin
        n_err++; $display("FAIL single_wait k=%0d got full=%b retval=%b want 0 0", k, full, retval);
      end
      if (k == 3) begin core_done = 1'b1; core_hit = 1'b1; end
    end
    @(negedge clk); core_done = 1'b0; core_hit = 1'b0;
    n_vec++; if (retval !== 1'b1 || ret_hit !== 1'b1 || ret_lat !== 8'd3 || full !== 1'b0) begin
      n_err++; $display("FAIL single_resp got retval=%b hit=%b lat=%0d full=%b want 1 1 3 0", retval, ret_hit, ret_lat, full);
    end
    @(negedge clk);
    n_vec++; if (retval !== 1'b0 || ret_hit !== 1'b0 || ret_lat !== '0) begin
      n_err++; $display("FAIL single_pulse got retval=%b hit=%b lat=%0d want 0 0 0", retval, ret_hit, ret_lat);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    core_stall = 1'b1;
    @(negedge clk); valid = 1'b1; opcode = 1'b0; addr = 8'h01;
    @(negedge clk); addr = 8'h02;
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL fo_full1 got %b want 0", full); end
    @(negedge clk); addr = 8'h03;
    n_vec++; if (full !== 1'b1 || overflow !== 1'b0) begin
      n_err++; $display("FAIL fo_full2 got full=%b ovf=%b want 1 0", full, overflow);
    end
    @(negedge clk); valid = 1'b0;
    n_vec++; if (full !== 1'b1 || overflow !== 1'b1) begin
      n_err++; $display("FAIL fo_drop got full=%b ovf=%b want 1 1", full, overflow);
    end
    n_vec++; if (core_req !== 1'b1 || core_addr !== 8'h01) begin
      n_err++; $display("FAIL fo_head got req=%b addr=%h want 1 01", core_req, core_addr);
    end
    serve(30, 2);
    n_vec++; if (obs_addr.size() != 2 || obs_hit.size() != 2) begin
      n_err++; $display("FAIL fo_count got issues=%0d rets=%0d want 2 2", obs_addr.size(), obs_hit.size());
    end else begin
      n_vec++; if (obs_addr[0] !== 8'h01 || obs_addr[1] !== 8'h02) begin
        n_err++; $display("FAIL fo_order got %h %h want 01 02", obs_addr[0], obs_addr[1]);
      end
      n_vec++; if (obs_hit[0] !== 1'b1 || obs_hit[1] !== 1'b0 || obs_lat[0] !== 8'd2 || obs_lat[1] !== 8'd2) begin
        n_err++; $display("FAIL fo_resp got hit=%b%b lat=%0d,%0d want hit=10 lat=2,2", obs_hit[0], obs_hit[1], obs_lat[0], obs_lat[1]);
      end
    end
    n_vec++; if (overflow !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL fo_sticky got ovf=%b full=%b want 1 0", overflow, full);
    end
  endtask

  task automatic test_stall_latency();
    bit ok;
    do_reset();
    core_stall = 1'b1;
    @(negedge clk); valid = 1'b1; opcode = 1'b0; addr = 8'h10;
    @(negedge clk); valid = 1'b0;
    wait_core_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_issue got no core_req want core_req"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++; if (core_req !== 1'b1 || core_addr !== 8'h10 || core_opcode !== 1'b0) begin
        n_err++; $display("FAIL stall_hold i=%0d got req=%b addr=%h want 1 10", i, core_req, core_addr);
      end
    end
    @(negedge clk);
    n_vec++; if (core_req !== 1'b1 || core_addr !== 8'h10) begin
      n_err++; $display("FAIL stall_accept got req=%b addr=%h want 1 10", core_req, core_addr);
    end
    core_stall = 1'b0;
    @(negedge clk); core_done = 1'b1; core_hit = 1'b0;
    n_vec++; if (core_req !== 1'b0) begin n_err++; $display("FAIL stall_req_drop got %b want 0", core_req); end
    @(negedge clk); core_done = 1'b0;
    n_vec++; if (retval !== 1'b1 || ret_hit !== 1'b0 || ret_lat !== 8'd1) begin
      n_err++; $display("FAIL stall_resp got retval=%b hit=%b lat=%0d want 1 0 1", retval, ret_hit, ret_lat);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int nret;
    do_reset();
    @(negedge clk); valid = 1'b1; opcode = 1'b1; addr = 8'h55;
    @(negedge clk); valid = 1'b0;
    wait_core_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL sat_issue got no core_req want core_req"); end
    nret = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (retval) nret++;
      if (k == 300) begin core_done = 1'b1; core_hit = 1'b1; end
    end
    n_vec++; if (nret != 0) begin n_err++; $display("FAIL sat_early got %0d retvals want 0", nret); end
    @(negedge clk); core_done = 1'b0; core_hit = 1'b0;
    n_vec++; if (retval !== 1'b1 || ret_lat !== 8'd255 || ret_hit !== 1'b1) begin
      n_err++; $display("FAIL sat_resp got retval=%b lat=%0d hit=%b want 1 255 1", retval, ret_lat, ret_hit);
    end
    nret = 0;
    repeat (5) begin @(negedge clk); if (retval) nret++; end
    n_vec++; if (nret != 0) begin n_err++; $display("FAIL sat_once got %0d extra retvals want 0", nret); end
  endtask

  task automatic test_reset_midflight();
    int nret;
    int nreq;
    do_reset();
    @(negedge clk); valid = 1'b1; opcode = 1'b1; addr = 8'hA5;
    @(negedge clk); opcode = 1'b0; addr = 8'hB6;
    @(negedge clk); valid = 1'b0;
    n_vec++; if (core_req !== 1'b1 || core_addr !== 8'hA5 || core_opcode !== 1'b1) begin
      n_err++; $display("FAIL mid_issue got req=%b addr=%h op=%b want 1 a5 1", core_req, core_addr, core_opcode);
    end
    @(negedge clk);
    n_vec++; if (core_req !== 1'b0 || core_addr !== 8'hA5) begin
      n_err++; $display("FAIL mid_hold got req=%b addr=%h want 0 a5", core_req, core_addr);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({full, retval, ret_hit, ret_lat, overflow, core_req, core_opcode, core_addr} !== '0) begin
      n_err++; $display("FAIL mid_async got full=%b ret=%b hit=%b lat=%0d ovf=%b req=%b op=%b addr=%h want all 0",
                        full, retval, ret_hit, ret_lat, overflow, core_req, core_opcode, core_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    nret = 0; nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (retval) nret++;
      if (core_req) nreq++;
    end
    n_vec++; if (nret != 0 || nreq != 0) begin
      n_err++; $display("FAIL mid_dropped got retvals=%0d reqs=%0d want 0 0", nret, nreq);
    end
    valid = 1'b1; opcode = 1'b0; addr = 8'h77;
    @(negedge clk); valid = 1'b0;
    serve(20, 3);
    n_vec++; if (obs_addr.size() != 1 || obs_hit.size() != 1) begin
      n_err++; $display("FAIL mid_after_count got issues=%0d rets=%0d want 1 1", obs_addr.size(), obs_hit.size());
    end else if (obs_addr[0] !== 8'h77 || obs_hit[0] !== 1'b1 || obs_lat[0] !== 8'd3) begin
      n_err++; $display("FAIL mid_after got addr=%h hit=%b lat=%0d want 77 1 3", obs_addr[0], obs_hit[0], obs_lat[0]);
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow got %b want 0", overflow); end
  endtask

  task automatic test_full_accept();
    do_reset();
    core_stall = 1'b1;
    @(negedge clk); valid = 1'b1; opcode = 1'b0; addr = 8'h31;
    @(negedge clk); addr = 8'h32;
    @(negedge clk);
    n_vec++; if (full !== 1'b1 || core_req !== 1'b1 || core_addr !== 8'h31) begin
      n_err++; $display("FAIL fa_pre got full=%b req=%b addr=%h want 1 1 31", full, core_req, core_addr);
    end
    addr = 8'h33; core_stall = 1'b0;
    @(negedge clk); valid = 1'b0;
    n_vec++; if (full !== 1'b0 || overflow !== 1'b1 || core_req !== 1'b0) begin
      n_err++; $display("FAIL fa_edge got full=%b ovf=%b req=%b want 0 1 0", full, overflow, core_req);
    end
    core_done = 1'b1; core_hit = 1'b1;
    @(negedge clk); core_done = 1'b0; core_hit = 1'b0;
    n_vec++; if (retval !== 1'b1 || ret_lat !== 8'd1 || ret_hit !== 1'b1) begin
      n_err++; $display("FAIL fa_resp got retval=%b lat=%0d hit=%b want 1 1 1", retval, ret_lat, ret_hit);
    end
    @(negedge clk);
    serve(30, 2);
    n_vec++; if (obs_addr.size() != 1 || obs_hit.size() != 1) begin
      n_err++; $display("FAIL fa_remaining got issues=%0d rets=%0d want 1 1", obs_addr.size(), obs_hit.size());
    end else if (obs_addr[0] !== 8'h32 || obs_hit[0] !== 1'b0 || obs_lat[0] !== 8'd2) begin
      n_err++; $display("FAIL fa_second got addr=%h hit=%b lat=%0d want 32 0 2", obs_addr[0], obs_hit[0], obs_lat[0]);
    end
  endtask

  // Random agent and core traffic against a queue model of the port
  task automatic test_random(input int n);
    req_t fq[$];
    logic exp_hit[$];
    int   exp_lat[$];
    req_t r;
    bit   ovf_m, busy, done_last;
    int   acc_cyc, done_cyc, idle_run, sz_pre, d, lat;
    logic eh;
    int   el;
    ovf_m = 1'b0; busy = 1'b0; done_last = 1'b0;
    acc_cyc = 0; done_cyc = 0; idle_run = 0;
    do_reset();
    for (int c = 0; c < n + 200; c++) begin
      @(negedge clk);
      n_vec++; if (full !== (fq.size() == int'(DEPTH))) begin
        n_err++; $display("FAIL rnd_full c=%0d got %b want %b", c, full, fq.size() == int'(DEPTH));
      end
      n_vec++; if (overflow !== ovf_m) begin
        n_err++; $display("FAIL rnd_overflow c=%0d got %b want %b", c, overflow, ovf_m);
      end
      n_vec++; if (retval !== done_last) begin
        n_err++; $display("FAIL rnd_retval c=%0d got %b want %b", c, retval, done_last);
      end
      if (retval && exp_hit.size() != 0) begin
        eh = exp_hit.pop_front();
        el = exp_lat.pop_front();
        n_vec++; if (ret_hit !== eh || ret_lat !== LAT_W'(el)) begin
          n_err++; $display("FAIL rnd_resp c=%0d got hit=%b lat=%0d want hit=%b lat=%0d", c, ret_hit, ret_lat, eh, el);
        end
      end else if (!retval) begin
        n_vec++; if (ret_hit !== 1'b0 || ret_lat !== '0) begin
          n_err++; $display("FAIL rnd_idle_ret c=%0d got hit=%b lat=%0d want 0 0", c, ret_hit, ret_lat);
        end
      end
      if (core_req) begin
        n_vec++;
        if (busy || fq.size() == 0) begin
          n_err++; $display("FAIL rnd_req c=%0d got core_req=1 want 0 (busy=%b queued=%0d)", c, busy, fq.size());
        end else if ({core_opcode, core_addr} !== {fq[0].op, fq[0].a}) begin
          n_err++; $display("FAIL rnd_issue c=%0d got op=%b addr=%h want op=%b addr=%h", c, core_opcode, core_addr, fq[0].op, fq[0].a);
        end
      end
      if (!busy && fq.size() != 0 && !core_req) idle_run++;
      else idle_run = 0;
      n_vec++; if (idle_run > 3) begin
        n_err++; $display("FAIL rnd_stuck c=%0d got no core_req for %0d cycles want issue", c, idle_run);
        idle_run = 0;
      end

      sz_pre = fq.size();
      core_done = 1'b0; core_hit = 1'b0; core_stall = 1'b0; done_last = 1'b0;
      if (busy) begin
        if (c == done_cyc) begin
          core_done = 1'b1; core_hit = 1'($urandom);
          lat = c - acc_cyc;
          if (lat < 1) lat = 1;
          if (lat > LAT_SAT) lat = LAT_SAT;
          exp_hit.push_back(core_hit); exp_lat.push_back(lat);
          busy = 1'b0; done_last = 1'b1;
        end
      end else if (core_req && fq.size() != 0) begin
        core_stall = ($urandom_range(0, 2) == 0);
        if (!core_stall) begin
          r = fq.pop_front();
          acc_cyc = c;
          d = $urandom_range(0, 5);
          if (d == 0) begin
            core_done = 1'b1; core_hit = 1'($urandom);
            exp_hit.push_back(core_hit); exp_lat.push_back(1);
            done_last = 1'b1;
          end else begin
            busy = 1'b1; done_cyc = c + d;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        core_done = 1'b1; core_hit = 1'b1;
      end

      if (c < n && $urandom_range(0, 1) == 1) begin
        valid = 1'b1; opcode = 1'($urandom); addr = ADDR_LEN'($urandom);
        if (sz_pre == int'(DEPTH)) ovf_m = 1'b1;
        else begin
          r.op = opcode; r.a = addr;
          fq.push_back(r);
        end
      end else begin
        valid = 1'b0;
      end
    end
    valid = 1'b0; core_done = 1'b0; core_stall = 1'b0;
    n_vec++; if (fq.size() != 0 || busy || exp_hit.size() != 0) begin
      n_err++; $display("FAIL rnd_drain got queued=%0d busy=%b pending=%0d want 0 0 0", fq.size(), busy, exp_hit.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_stall_latency();
    test_saturate();
    test_reset_midflight();
    test_full_accept();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
